// File: rtl/clock_pkg.sv
// Shared clock types: set-mode state encoding, also used by the display mux.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOUR = 2'd1,
        MIN  = 2'd2,
        SEC  = 2'd3
    } set_state_t;

    function automatic set_state_t next_set_state(input set_state_t s);
        case (s)
            RUN:     return HOUR;
            HOUR:    return MIN;
            MIN:     return SEC;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/press_detect.sv
// Edge and hold-length classification for one debounced button level.
module press_detect #(
    parameter int unsigned LONG_MS = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise,
    output logic fall,
    output logic fall_short,
    output logic long_hit,
    output logic held
);
    localparam int unsigned HoldW = $clog2(LONG_MS + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_MS);

    logic             prev_q;
    logic [HoldW-1:0] hold_q, hold_d;

    assign rise       = btn & ~prev_q;
    assign fall       = ~btn & prev_q;
    // hold_q still carries the press length on the fall cycle
    assign fall_short = fall & (hold_q < HoldMax);
    assign long_hit   = btn & (hold_q == HoldMax - 1'b1);
    assign held       = btn & (hold_q == HoldMax);

    always_comb begin
        hold_d = hold_q;
        if (!btn) begin
            hold_d = '0;
        end else if (hold_q < HoldMax) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            hold_q <= '0;
        end else begin
            prev_q <= btn;
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: RUN/HOUR/MIN/SEC sequencing, inc pulses, idle timeout, blink.
// Optional auto-repeat of a held inc button: define CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned LONG_MS    = 1000,
    parameter int unsigned REPEAT_MS  = 200,
    parameter int unsigned TIMEOUT_MS = 30000,
    parameter int unsigned BLINK_MS   = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [1:0] set_state,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       sec_clr,
    output logic       blink
);
    localparam int unsigned IdleW  = $clog2(TIMEOUT_MS + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_MS + 1);
    localparam logic [IdleW-1:0]  IdleMax   = IdleW'(TIMEOUT_MS);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_MS - 1);

    set_state_t        state_q, state_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
    logic              blink_d;
    logic              mode_rise, mode_fall, mode_short, mode_long, mode_held;
    logic              inc_rise, inc_fall, inc_fall_short, inc_long_hit, inc_held;
    logic              mode_exit, mode_act, timeout, chg, inc_fire, inc_rep, activity;
    logic              unused_press;

    press_detect #(.LONG_MS(LONG_MS)) u_mode (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (mode_btn),
        .rise       (mode_rise),
        .fall       (mode_fall),
        .fall_short (mode_short),
        .long_hit   (mode_long),
        .held       (mode_held)
    );

    press_detect #(.LONG_MS(LONG_MS)) u_inc (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn        (inc_btn),
        .rise       (inc_rise),
        .fall       (inc_fall),
        .fall_short (inc_fall_short),
        .long_hit   (inc_long_hit),
        .held       (inc_held)
    );

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_MS + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_MS - 1);

    logic [RepW-1:0] rep_q, rep_d;

    // Phase zero of the repeat counter is a repeat slot; it restarts on release or state change
    assign inc_rep = inc_held && (rep_q == '0) && (state_q != RUN);

    always_comb begin
        rep_d = rep_q;
        if (!inc_held || chg || (state_q == RUN)) begin
            rep_d = '0;
        end else if (rep_q == RepLast) begin
            rep_d = '0;
        end else begin
            rep_d = rep_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign unused_press = ^{mode_held, inc_fall_short, inc_long_hit};
`else
    assign inc_rep      = 1'b0;
    assign unused_press = ^{mode_held, inc_fall_short, inc_long_hit, inc_held, REPEAT_MS};
`endif

    always_comb begin
        mode_exit = mode_long && (state_q != RUN);
        mode_act  = mode_short || mode_exit;
        timeout   = (state_q != RUN) && (idle_q == IdleMax - 1'b1);

        state_d = state_q;
        if (mode_short) begin
            state_d = next_set_state(state_q);
        end else if (mode_exit || timeout) begin
            state_d = RUN;
        end
        chg = (state_d != state_q);

        inc_fire = (state_q != RUN) && (inc_rise || inc_rep) && !mode_act && !timeout;
        activity = mode_rise | mode_fall | inc_rise | inc_fall | inc_rep;

        idle_d = idle_q;
        if (chg || activity || (state_q == RUN)) begin
            idle_d = '0;
        end else if (idle_q < IdleMax) begin
            idle_d = idle_q + 1'b1;
        end

        // A fired pulse restarts the phase so the new value is shown immediately
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink;
        if ((state_d == RUN) || chg || inc_fire) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            blink_d     = ~blink;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            idle_q      <= '0;
            blink_cnt_q <= '0;
            blink       <= 1'b0;
            inc_hour    <= 1'b0;
            inc_min     <= 1'b0;
            sec_clr     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            blink_cnt_q <= blink_cnt_d;
            blink       <= blink_d;
            inc_hour    <= inc_fire && (state_q == HOUR);
            inc_min     <= inc_fire && (state_q == MIN);
            sec_clr     <= inc_fire && (state_q == SEC);
        end
    end

    assign set_state = state_q;
    assign run_en    = (state_q == RUN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized and directed bench for clock_set_ctrl against an event-level reference model.
module tb_clock_set_ctrl;
    localparam int unsigned LONG = 10;
    localparam int unsigned REP  = 4;
    localparam int unsigned TMO  = 50;
    localparam int unsigned BLK  = 5;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [1:0] set_state;
    logic       run_en, inc_hour, inc_min, sec_clr, blink;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .LONG_MS    (LONG),
        .REPEAT_MS  (REP),
        .TIMEOUT_MS (TMO),
        .BLINK_MS   (BLK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_btn  (mode_btn),
        .inc_btn   (inc_btn),
        .set_state (set_state),
        .run_en    (run_en),
        .inc_hour  (inc_hour),
        .inc_min   (inc_min),
        .sec_clr   (sec_clr),
        .blink     (blink)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_hour = 0;
    int cnt_min  = 0;
    int cnt_sec  = 0;

    // Reference model: press lengths, time since last activity, time since phase restart
    int m_state, m_mode_len, m_inc_len, m_idle, m_age, m_pulse, m_anchor;
    bit m_mode_prev, m_inc_prev;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_mode_len = 0; m_inc_len = 0; m_idle = 0; m_age = 0; m_pulse = 0;
        m_anchor = LONG; m_mode_prev = 0; m_inc_prev = 0;
    endtask

    task automatic model_step(input bit m, input bit i);
        bit mr, mf, ir, fi, short_p, long_x, tmo, rep, fire, chg;
        int nxt;
        mr = m && !m_mode_prev;
        mf = !m && m_mode_prev;
        ir = i && !m_inc_prev;
        fi = !i && m_inc_prev;
        short_p = mf && (m_mode_len < LONG);
        long_x  = m && (m_mode_len + 1 == LONG) && (m_state != 0);
        tmo     = (m_state != 0) && (m_idle + 1 >= TMO);
        rep     = REP_EN && (m_state != 0) && i && (m_inc_len >= m_anchor)
                  && (((m_inc_len - m_anchor) % REP) == 0);
        nxt = short_p ? (m_state + 1) % 4 : ((long_x || tmo) ? 0 : m_state);
        fire = (m_state != 0) && (ir || rep) && !(short_p || long_x) && !tmo;
        m_pulse = fire ? m_state : 0;
        chg = (nxt != m_state);
        m_idle = (chg || mr || mf || ir || fi || rep || nxt == 0) ? 0 : m_idle + 1;
        m_age  = (nxt == 0 || chg || fire) ? 0 : m_age + 1;
        if (!i) m_anchor = LONG;
        else if (chg) m_anchor = (m_inc_len + 1 > LONG) ? m_inc_len + 1 : LONG;
        m_inc_len  = i ? m_inc_len + 1 : 0;
        m_mode_len = m ? m_mode_len + 1 : 0;
        m_mode_prev = m;
        m_inc_prev  = i;
        m_state = nxt;
    endtask

    task automatic compare();
        check("set_state", int'(set_state), m_state);
        check("run_en", int'(run_en), int'(m_state == 0));
        check("inc_hour", int'(inc_hour), int'(m_pulse == 1));
        check("inc_min", int'(inc_min), int'(m_pulse == 2));
        check("sec_clr", int'(sec_clr), int'(m_pulse == 3));
        check("blink", int'(blink), (m_age / BLK) % 2);
        cnt_hour += int'(inc_hour);
        cnt_min  += int'(inc_min);
        cnt_sec  += int'(sec_clr);
    endtask

    task automatic tick(input bit m, input bit i);
        mode_btn = m;
        inc_btn  = i;
        @(posedge clk);
        model_step(m, i);
        @(negedge clk);
        compare();
    endtask

    task automatic press(input int n);
        repeat (n) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        int c;
        int run_m, run_i;
        bit lm, li;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;

        repeat (100) tick(1'b0, 1'b0);
        check("idle_state", int'(set_state), 0);
        check("idle_run_en", int'(run_en), 1);
        check("idle_pulses", cnt_hour + cnt_min + cnt_sec, 0);

        for (int k = 0; k < 4; k++) begin
            press(3);
            check($sformatf("advance_%0d", k), int'(set_state), (k + 1) % 4);
        end

        press(3);
        c = cnt_hour;
        tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("hour_once", cnt_hour - c, 1);
        press(3); press(3);
        c = cnt_sec;
        tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("sec_once", cnt_sec - c, 1);
        press(3);
        c = cnt_hour + cnt_min + cnt_sec;
        tick(1'b0, 1'b1); tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("run_no_pulse", cnt_hour + cnt_min + cnt_sec - c, 0);

        press(3); press(3);
        c = cnt_min;
        repeat (30) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("min_hold", cnt_min - c, REP_EN ? 6 : 1);

        press(3); press(3); press(3);
        check("long_in_hour", int'(set_state), 1);
        repeat (9) tick(1'b1, 1'b0);
        check("long_pre", int'(set_state), 1);
        tick(1'b1, 1'b0);
        check("long_exit", int'(set_state), 0);
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        check("long_release", int'(set_state), 0);

        press(3); press(3);
        for (int k = 1; k <= 50; k++) begin
            tick(1'b0, 1'b0);
            if (k == 4)  check("blink_k4", int'(blink), 0);
            if (k == 5)  check("blink_k5", int'(blink), 1);
            if (k == 10) check("blink_k10", int'(blink), 0);
            if (k == 49) check("timeout_pre", int'(set_state), 2);
            if (k == 50) check("timeout_run", int'(set_state), 0);
        end

        press(3); press(3);
        repeat (3) tick(1'b0, 1'b0);
        repeat (3) tick(1'b1, 1'b0);
        c = cnt_min + cnt_sec;
        tick(1'b0, 1'b1);
        check("coinc_state", int'(set_state), 3);
        check("coinc_no_pulse", cnt_min + cnt_sec - c, 0);
        tick(1'b0, 1'b0);

        run_m = 0; run_i = 0; lm = 0; li = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) begin
                mode_btn = 1'b0; inc_btn = 1'b0;
                rst_n = 1'b0;
                model_reset();
                #1 compare();
                @(negedge clk);
                compare();
                rst_n = 1'b1;
                run_m = 0; run_i = 0;
            end
            if ($urandom_range(0, 199) == 0) repeat (60) tick(1'b0, 1'b0);
            if (run_m == 0) begin
                lm = 1'($urandom_range(0, 1));
                run_m = lm ? (($urandom_range(0, 3) == 0) ? $urandom_range(8, 14)
                                                           : $urandom_range(1, 4))
                           : $urandom_range(1, 20);
            end
            if (run_i == 0) begin
                li = 1'($urandom_range(0, 1));
                run_i = li ? (($urandom_range(0, 3) == 0) ? $urandom_range(9, 30)
                                                           : $urandom_range(1, 3))
                           : $urandom_range(1, 15);
            end
            tick(lm, li);
            run_m--;
            run_i--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
